// File: rtl/apb_master_bridge.sv
//==============================================================================
// Module      : apb_master_bridge
// Description : Converts a single-outstanding command/response handshake into
//               APB transfers. Waits at most TIMEOUT cycles in ACCESS for
//               pready before reporting a timeout error.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module apb_master_bridge #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        pclk,
    input  logic        presetn,
    // Command side
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    // Response side
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    // APB requester
    output logic [31:0] paddr,
    output logic [7:0]  pwdata,
    output logic        pwrite,
    output logic        psel,
    output logic        penable,
    // APB completer
    input  logic [7:0]  prdata,
    input  logic        pready,
    input  logic        pslverr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // Last ACCESS cycle index before giving up on pready
    localparam logic [7:0] C_WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q,   state_d;
    logic [31:0] paddr_q,   paddr_d;
    logic [7:0]  pwdata_q,  pwdata_d;
    logic        pwrite_q,  pwrite_d;
    logic [7:0]  rdata_q,   rdata_d;
    logic        err_q,     err_d;
    logic        tmo_q,     tmo_d;
    logic [7:0]  wait_q,    wait_d;

    // Next-state and datapath decisions; APB inputs are only looked at in ACCESS
    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        wait_d   = wait_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_wdata;
                    wait_d   = 8'd0;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                wait_d  = 8'd0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                // pready wins even on the final permitted wait cycle
                if (pready) begin
                    rdata_d = (pwrite_q || pslverr) ? 8'h00 : prdata;
                    err_d   = pslverr;
                    tmo_d   = 1'b0;
                    state_d = S_RESP;
                end else if (wait_q == C_WAIT_LAST) begin
                    rdata_d = 8'h00;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transfer in flight
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q  <= S_IDLE;
            paddr_q  <= 32'd0;
            pwdata_q <= 8'd0;
            pwrite_q <= 1'b0;
            rdata_q  <= 8'd0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
            wait_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            wait_q   <= wait_d;
        end
    end

    // Control outputs decode straight from the registered state
    assign cmd_ready   = (state_q == S_IDLE);
    assign psel        = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign penable     = (state_q == S_ACCESS);
    assign rsp_valid   = (state_q == S_RESP);
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign pwrite      = pwrite_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
//==============================================================================
// Module      : tb_apb_master_bridge
// Description : Directed self-checking bench for apb_master_bridge with an
//               APB completer model and a response scoreboard.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_apb_master_bridge;

    localparam int TMO = 16;

    logic        pclk      = 1'b0;
    logic        presetn   = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr  = 32'd0;
    logic [7:0]  cmd_wdata = 8'd0;
    logic        rsp_ready = 1'b0;
    logic [7:0]  prdata    = 8'd0;
    logic        pready    = 1'b0;
    logic        pslverr   = 1'b0;
    logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
    logic [7:0]  rsp_rdata, pwdata;
    logic [31:0] paddr;
    logic        pwrite, psel, penable;

    apb_master_bridge #(.TIMEOUT(TMO)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        logic       tmo;
        int         lat;
        int         n_psel;
        int         n_pen;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Completer configuration
    int         slv_wait  = 0;
    bit         slv_never = 1'b0;
    logic [7:0] slv_rdata = 8'h00;
    logic       slv_err   = 1'b0;
    int         acc_cnt   = 0;

    // Bus monitor state
    int          psel_cnt = 0;
    int          pen_cnt  = 0;
    int          stab_err = 0;
    logic [31:0] m_addr   = 32'd0;
    logic        m_wr     = 1'b0;
    logic [7:0]  m_wd     = 8'd0;

    // Monitor APB request stability and drive the completer; noise outside ACCESS
    always @(negedge pclk) begin
        if (psel) begin
            psel_cnt++;
            if (penable) pen_cnt++;
            if (paddr !== m_addr || pwrite !== m_wr || pwdata !== m_wd) stab_err++;
        end
        if (psel && penable) begin
            pready = !slv_never && (acc_cnt == slv_wait);
            if (pready) begin
                prdata  = slv_rdata;
                pslverr = slv_err;
            end else begin
                prdata  = 8'($urandom);
                pslverr = 1'($urandom);
            end
            acc_cnt++;
        end else begin
            pready  = 1'($urandom);
            pslverr = 1'($urandom);
            prdata  = 8'($urandom);
            acc_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Present a command at the current negedge, wait for acceptance, push expectation
    task automatic send(input logic wr, input logic [31:0] a, input logic [7:0] d,
                        input bit expect_rsp, input logic [7:0] e_rdata, input logic e_err,
                        input logic e_tmo, input int e_lat, input int e_psel, input int e_pen);
        exp_t e;
        int   guard = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && guard < 50) begin
            @(negedge pclk);
            guard++;
        end
        chk("cmd accepted", cmd_ready, 1);
        m_addr   = a;
        m_wr     = wr;
        m_wd     = d;
        psel_cnt = 0;
        pen_cnt  = 0;
        stab_err = 0;
        if (expect_rsp) begin
            e.rdata  = e_rdata;
            e.err    = e_err;
            e.tmo    = e_tmo;
            e.lat    = e_lat;
            e.n_psel = e_psel;
            e.n_pen  = e_pen;
            sb.push_back(e);
        end
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_addr  = 32'($urandom);
        cmd_wdata = 8'($urandom);
        cmd_write = 1'($urandom);
    endtask

    // Wait for the response, compare against the scoreboard, stall, then handshake
    task automatic wait_rsp(input int hold);
        exp_t e;
        int   lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(negedge pclk);
            lat++;
        end
        chk("rsp_valid seen", rsp_valid, 1);
        chk("scoreboard entry", sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("latency", lat, e.lat);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_timeout", rsp_timeout, e.tmo);
            chk("psel cycles", psel_cnt, e.n_psel);
            chk("penable cycles", pen_cnt, e.n_pen);
            chk("request stable", stab_err, 0);
            for (int i = 0; i < hold; i++) begin
                @(negedge pclk);
                chk("hold rsp_valid", rsp_valid, 1);
                chk("hold rsp_rdata", rsp_rdata, e.rdata);
                chk("hold rsp_err", rsp_err, e.err);
                chk("hold rsp_timeout", rsp_timeout, e.tmo);
                chk("hold cmd_ready", cmd_ready, 0);
                chk("hold psel", psel, 0);
            end
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        chk("post-handshake cmd_ready", cmd_ready, 1);
        chk("post-handshake rsp_valid", rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while presetn is held low
        #12;
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset psel", psel, 0);
        chk("reset penable", penable, 0);
        chk("reset pwrite", pwrite, 0);
        chk("reset paddr", paddr, 0);
        chk("reset pwdata", pwdata, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_rdata", rsp_rdata, 0);
        chk("reset rsp_err", rsp_err, 0);
        chk("reset rsp_timeout", rsp_timeout, 0);
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);

        // Write, zero wait states; stall the response 2 cycles
        slv_wait = 0; slv_never = 0; slv_err = 0; slv_rdata = 8'h00;
        send(1'b1, 32'd5, 8'hA5, 1, 8'h00, 1'b0, 1'b0, 3, 2, 1);
        wait_rsp(2);

        // Back-to-back read of the same address, three wait states
        slv_wait = 3; slv_rdata = 8'hA5;
        send(1'b0, 32'd5, 8'h3C, 1, 8'hA5, 1'b0, 1'b0, 6, 5, 4);
        wait_rsp(0);

        // Read with completer error; response held off for 5 cycles
        slv_wait = 0; slv_rdata = 8'h5A; slv_err = 1;
        send(1'b0, 32'd20, 8'h00, 1, 8'h00, 1'b1, 1'b0, 3, 2, 1);
        wait_rsp(5);

        // Write with completer error
        send(1'b1, 32'h8, 8'h11, 1, 8'h00, 1'b1, 1'b0, 3, 2, 1);
        wait_rsp(1);

        // Completer never ready: timeout after exactly TMO ACCESS cycles
        slv_err = 0; slv_never = 1;
        send(1'b0, 32'h30, 8'h00, 1, 8'h00, 1'b1, 1'b1, TMO + 2, TMO + 1, TMO);
        wait_rsp(1);

        // pready on the final permitted ACCESS cycle completes normally
        slv_never = 0; slv_wait = TMO - 1; slv_rdata = 8'h77;
        send(1'b0, 32'h34, 8'h00, 1, 8'h77, 1'b0, 1'b0, TMO + 2, TMO + 1, TMO);
        wait_rsp(0);

        // Reset asserted mid-ACCESS abandons the transfer
        slv_never = 1;
        send(1'b0, 32'h40, 8'h00, 0, 8'h00, 1'b0, 1'b0, 0, 0, 0);
        @(negedge pclk);
        chk("abort in ACCESS", penable, 1);
        #2;
        presetn = 1'b0;
        #1;
        chk("async reset psel", psel, 0);
        chk("async reset penable", penable, 0);
        chk("async reset paddr", paddr, 0);
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        chk("after reset cmd_ready", cmd_ready, 1);
        for (int i = 0; i < 3; i++) begin
            chk("after reset no rsp_valid", rsp_valid, 0);
            @(negedge pclk);
        end

        // Normal transfer after the abort
        slv_never = 0; slv_wait = 1; slv_rdata = 8'hC3;
        send(1'b0, 32'h44, 8'h9E, 1, 8'hC3, 1'b0, 1'b0, 4, 3, 2);
        wait_rsp(0);

        chk("scoreboard drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
